// File: rtl/bram_port_arbiter_if.sv
// Bus bundle between two BRAM-style requesters (A, B), the arbiter and one
// single-port BRAM.
interface bram_port_arbiter_if #(
  parameter int DATA_WIDTH      = 64,
  parameter int BRAM_ADDR_WIDTH = 12
);
  // Handshake: an access transfers in the cycle where req && gnt. The requester
  // holds req and its payload stable until gnt; gnt never rises without req.
  logic                         a_req;
  logic                         a_gnt;
  logic [DATA_WIDTH/8-1:0]      a_we;
  logic [BRAM_ADDR_WIDTH-1:0]   a_addr;
  logic [DATA_WIDTH-1:0]        a_wrdata;
  logic                         a_rvalid;
  logic [DATA_WIDTH-1:0]        a_rddata;

  logic                         b_req;
  logic                         b_gnt;
  logic [DATA_WIDTH/8-1:0]      b_we;
  logic [BRAM_ADDR_WIDTH-1:0]   b_addr;
  logic [DATA_WIDTH-1:0]        b_wrdata;
  logic                         b_rvalid;
  logic [DATA_WIDTH-1:0]        b_rddata;

  logic                         bram_en;
  logic [DATA_WIDTH/8-1:0]      bram_we;
  logic [BRAM_ADDR_WIDTH-1:0]   bram_addr;
  logic [DATA_WIDTH-1:0]        bram_wrdata;
  logic [DATA_WIDTH-1:0]        bram_rddata;

  modport slave (
    input  a_req, a_we, a_addr, a_wrdata,
    input  b_req, b_we, b_addr, b_wrdata,
    input  bram_rddata,
    output a_gnt, a_rvalid, a_rddata,
    output b_gnt, b_rvalid, b_rddata,
    output bram_en, bram_we, bram_addr, bram_wrdata
  );

  modport master (
    output a_req, a_we, a_addr, a_wrdata,
    output b_req, b_we, b_addr, b_wrdata,
    output bram_rddata,
    input  a_gnt, a_rvalid, a_rddata,
    input  b_gnt, b_rvalid, b_rddata,
    input  bram_en, bram_we, bram_addr, bram_wrdata
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// Round-robin sharing of one single-port BRAM between requesters A and B, with
// a read-ownership pipeline so each read's rvalid returns to its issuer only.
module bram_port_arbiter #(
  parameter int DATA_WIDTH      = 64,
  parameter int BRAM_ADDR_WIDTH = 12,
  parameter int READ_LATENCY    = 1
) (
  input  logic               clk,
  input  logic               rstn,
  bram_port_arbiter_if.slave bus
);
  typedef enum logic {OWNER_A = 1'b0, OWNER_B = 1'b1} owner_e;

  owner_e                  last_owner;
  owner_e                  pipe_owner [READ_LATENCY];
  logic [READ_LATENCY-1:0] pipe_valid;
  logic                    a_gnt;
  logic                    b_gnt;
  logic                    rd_issue;

  // On a tie the requester that did not win last time is granted; nothing is
  // granted while reset is held.
  assign a_gnt = rstn && bus.a_req && (!bus.b_req || last_owner == OWNER_B);
  assign b_gnt = rstn && bus.b_req && (!bus.a_req || last_owner == OWNER_A);

  assign rd_issue = (a_gnt && bus.a_we == '0) || (b_gnt && bus.b_we == '0);

  assign bus.a_gnt       = a_gnt;
  assign bus.b_gnt       = b_gnt;
  assign bus.bram_en     = a_gnt || b_gnt;
  assign bus.bram_we     = a_gnt ? bus.a_we : (b_gnt ? bus.b_we : '0);
  assign bus.bram_addr   = a_gnt ? bus.a_addr : bus.b_addr;
  assign bus.bram_wrdata = a_gnt ? bus.a_wrdata : bus.b_wrdata;

  assign bus.a_rddata = bus.bram_rddata;
  assign bus.b_rddata = bus.bram_rddata;
  assign bus.a_rvalid = pipe_valid[READ_LATENCY-1] && pipe_owner[READ_LATENCY-1] == OWNER_A;
  assign bus.b_rvalid = pipe_valid[READ_LATENCY-1] && pipe_owner[READ_LATENCY-1] == OWNER_B;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_owner <= OWNER_B;
      pipe_valid <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_owner[i] <= OWNER_A;
      end
    end else begin
      if (a_gnt) begin
        last_owner <= OWNER_A;
      end else if (b_gnt) begin
        last_owner <= OWNER_B;
      end
      // Stage 0 captures this cycle's read; the last stage lines up with bram_rddata.
      pipe_valid[0] <= rd_issue;
      pipe_owner[0] <= a_gnt ? OWNER_A : OWNER_B;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_owner[i] <= pipe_owner[i-1];
      end
    end
  end
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench: two arbiter instances (read latency 1 and 3), each with a
// behavioural BRAM whose initial contents are {16'hBEEF, 36'h0, addr}.
module tb_bram_port_arbiter;
  logic clk;
  logic rstn;
  int   tests_run;
  int   tests_failed;

  bram_port_arbiter_if #(.DATA_WIDTH(64), .BRAM_ADDR_WIDTH(12)) if1 ();
  bram_port_arbiter_if #(.DATA_WIDTH(64), .BRAM_ADDR_WIDTH(12)) if3 ();

  bram_port_arbiter #(.DATA_WIDTH(64), .BRAM_ADDR_WIDTH(12), .READ_LATENCY(1)) dut1 (
    .clk(clk), .rstn(rstn), .bus(if1)
  );
  bram_port_arbiter #(.DATA_WIDTH(64), .BRAM_ADDR_WIDTH(12), .READ_LATENCY(3)) dut3 (
    .clk(clk), .rstn(rstn), .bus(if3)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] pat(input logic [11:0] a);
    return {16'hBEEF, 36'h0, a};
  endfunction

  // BRAM models: memory contents are re-seeded on every clock seen in reset
  logic [63:0] mem1 [4096];
  logic [63:0] mem3 [4096];
  logic [63:0] rd3 [3];

  always @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < 4096; i++) mem1[i] <= pat(i[11:0]);
    end else if (if1.bram_en) begin
      for (int i = 0; i < 8; i++)
        if (if1.bram_we[i]) mem1[if1.bram_addr][i*8 +: 8] <= if1.bram_wrdata[i*8 +: 8];
      if1.bram_rddata <= mem1[if1.bram_addr];
    end
  end

  always @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < 4096; i++) mem3[i] <= pat(i[11:0]);
    end else begin
      if (if3.bram_en) begin
        for (int i = 0; i < 8; i++)
          if (if3.bram_we[i]) mem3[if3.bram_addr][i*8 +: 8] <= if3.bram_wrdata[i*8 +: 8];
        rd3[0] <= mem3[if3.bram_addr];
      end
      rd3[1] <= rd3[0];
      rd3[2] <= rd3[1];
    end
  end
  assign if3.bram_rddata = rd3[2];

  // driver tasks
  task automatic idle_all();
    if1.a_req = 0; if1.a_we = '0; if1.a_addr = '0; if1.a_wrdata = '0;
    if1.b_req = 0; if1.b_we = '0; if1.b_addr = '0; if1.b_wrdata = '0;
    if3.a_req = 0; if3.a_we = '0; if3.a_addr = '0; if3.a_wrdata = '0;
    if3.b_req = 0; if3.b_we = '0; if3.b_addr = '0; if3.b_wrdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    idle_all();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // tests
  task automatic test_reset();
    rstn = 1'b0;
    idle_all();
    if1.a_req = 1; if1.b_req = 1; if3.a_req = 1; if3.b_req = 1;
    @(negedge clk); #1;
    tests_run++; if (if1.a_gnt !== 1'b0) begin tests_failed++; $display("FAIL reset_a_gnt: got %b expected 0", if1.a_gnt); end
    tests_run++; if (if1.b_gnt !== 1'b0) begin tests_failed++; $display("FAIL reset_b_gnt: got %b expected 0", if1.b_gnt); end
    tests_run++; if (if1.bram_en !== 1'b0) begin tests_failed++; $display("FAIL reset_bram_en: got %b expected 0", if1.bram_en); end
    tests_run++; if (if1.bram_we !== 8'h00) begin tests_failed++; $display("FAIL reset_bram_we: got %h expected 00", if1.bram_we); end
    tests_run++; if ({if1.a_rvalid, if1.b_rvalid} !== 2'b00) begin tests_failed++; $display("FAIL reset_rvalid: got %b expected 00", {if1.a_rvalid, if1.b_rvalid}); end
    tests_run++; if ({if3.a_gnt, if3.b_gnt, if3.bram_en} !== 3'b000) begin tests_failed++; $display("FAIL reset_l3_gnt_en: got %b expected 000", {if3.a_gnt, if3.b_gnt, if3.bram_en}); end
    idle_all();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_single_read();
    @(negedge clk);
    if1.a_req = 1; if1.a_we = '0; if1.a_addr = 12'h010;
    #1;
    tests_run++; if (if1.a_gnt !== 1'b1) begin tests_failed++; $display("FAIL single_a_gnt: got %b expected 1", if1.a_gnt); end
    tests_run++; if (if1.b_gnt !== 1'b0) begin tests_failed++; $display("FAIL single_b_gnt: got %b expected 0", if1.b_gnt); end
    tests_run++; if (if1.bram_en !== 1'b1) begin tests_failed++; $display("FAIL single_bram_en: got %b expected 1", if1.bram_en); end
    tests_run++; if (if1.bram_addr !== 12'h010) begin tests_failed++; $display("FAIL single_bram_addr: got %h expected 010", if1.bram_addr); end
    tests_run++; if (if1.bram_we !== 8'h00) begin tests_failed++; $display("FAIL single_bram_we: got %h expected 00", if1.bram_we); end
    @(negedge clk);
    if1.a_req = 0;
    #1;
    tests_run++; if (if1.a_rvalid !== 1'b1) begin tests_failed++; $display("FAIL single_a_rvalid: got %b expected 1", if1.a_rvalid); end
    tests_run++; if (if1.a_rddata !== 64'hBEEF_0000_0000_0010) begin tests_failed++; $display("FAIL single_a_rddata: got %h expected beef000000000010", if1.a_rddata); end
    tests_run++; if (if1.b_rvalid !== 1'b0) begin tests_failed++; $display("FAIL single_b_rvalid: got %b expected 0", if1.b_rvalid); end
    @(negedge clk); #1;
    tests_run++; if (if1.a_rvalid !== 1'b0) begin tests_failed++; $display("FAIL single_a_rvalid_pulse: got %b expected 0", if1.a_rvalid); end
  endtask

  task automatic test_dual_read();
    logic        exp_a;
    logic [63:0] exp_d;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k < 4) begin
        if1.a_req = 1; if1.a_we = '0; if1.a_addr = 12'h001;
        if1.b_req = 1; if1.b_we = '0; if1.b_addr = 12'h002;
      end else begin
        if1.a_req = 0; if1.b_req = 0;
      end
      #1;
      if (k < 4) begin
        exp_a = (k % 2 == 0);
        tests_run++; if ({if1.a_gnt, if1.b_gnt} !== {exp_a, !exp_a}) begin tests_failed++; $display("FAIL dual_gnt[%0d]: got %b expected %b", k, {if1.a_gnt, if1.b_gnt}, {exp_a, !exp_a}); end
        tests_run++; if (if1.bram_addr !== (exp_a ? 12'h001 : 12'h002)) begin tests_failed++; $display("FAIL dual_addr[%0d]: got %h", k, if1.bram_addr); end
      end
      if (k >= 1) begin
        exp_a = ((k - 1) % 2 == 0);
        exp_d = exp_a ? 64'hBEEF_0000_0000_0001 : 64'hBEEF_0000_0000_0002;
        tests_run++; if ({if1.a_rvalid, if1.b_rvalid} !== {exp_a, !exp_a}) begin tests_failed++; $display("FAIL dual_rvalid[%0d]: got %b expected %b", k, {if1.a_rvalid, if1.b_rvalid}, {exp_a, !exp_a}); end
        tests_run++; if (if1.a_rddata !== exp_d) begin tests_failed++; $display("FAIL dual_rddata[%0d]: got %h expected %h", k, if1.a_rddata, exp_d); end
      end
    end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    if1.a_req = 1; if1.a_we = 8'hF0; if1.a_addr = 12'h020; if1.a_wrdata = 64'hDEADBEEF_00000000;
    if1.b_req = 0;
    #1;
    tests_run++; if (if1.a_gnt !== 1'b1) begin tests_failed++; $display("FAIL wr_a_gnt: got %b expected 1", if1.a_gnt); end
    tests_run++; if (if1.bram_we !== 8'hF0) begin tests_failed++; $display("FAIL wr_bram_we: got %h expected f0", if1.bram_we); end
    tests_run++; if (if1.bram_wrdata !== 64'hDEADBEEF_00000000) begin tests_failed++; $display("FAIL wr_bram_wrdata: got %h expected deadbeef00000000", if1.bram_wrdata); end
    @(negedge clk);
    if1.a_req = 0; if1.a_we = '0;
    if1.b_req = 1; if1.b_we = '0; if1.b_addr = 12'h020;
    #1;
    tests_run++; if (if1.b_gnt !== 1'b1) begin tests_failed++; $display("FAIL rd_b_gnt: got %b expected 1", if1.b_gnt); end
    tests_run++; if (if1.a_rvalid !== 1'b0) begin tests_failed++; $display("FAIL wr_no_a_rvalid: got %b expected 0", if1.a_rvalid); end
    @(negedge clk);
    if1.b_req = 0;
    #1;
    tests_run++; if (if1.b_rvalid !== 1'b1) begin tests_failed++; $display("FAIL raw_b_rvalid: got %b expected 1", if1.b_rvalid); end
    tests_run++; if (if1.b_rddata !== 64'hDEADBEEF_00000020) begin tests_failed++; $display("FAIL raw_b_rddata: got %h expected deadbeef00000020", if1.b_rddata); end
    tests_run++; if (if1.a_rvalid !== 1'b0) begin tests_failed++; $display("FAIL raw_a_rvalid: got %b expected 0", if1.a_rvalid); end
  endtask

  task automatic test_latency3();
    int   j;
    int   pulses;
    logic exp_a;
    logic exp_b;
    do_reset();
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k < 6) begin
        if3.a_req = 1; if3.a_we = '0; if3.a_addr = 12'h003;
        if3.b_req = 1; if3.b_we = '0; if3.b_addr = 12'h004;
      end else begin
        if3.a_req = 0; if3.b_req = 0;
      end
      #1;
      if (k < 6) begin
        tests_run++; if ({if3.a_gnt, if3.b_gnt} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin tests_failed++; $display("FAIL l3_gnt[%0d]: got %b", k, {if3.a_gnt, if3.b_gnt}); end
      end
      j = k - 3;
      exp_a = (j >= 0) && (j < 6) && (j % 2 == 0);
      exp_b = (j >= 0) && (j < 6) && (j % 2 == 1);
      tests_run++; if ({if3.a_rvalid, if3.b_rvalid} !== {exp_a, exp_b}) begin tests_failed++; $display("FAIL l3_rvalid[%0d]: got %b expected %b", k, {if3.a_rvalid, if3.b_rvalid}, {exp_a, exp_b}); end
      if (exp_a || exp_b) begin
        tests_run++; if (if3.a_rddata !== (exp_a ? 64'hBEEF_0000_0000_0003 : 64'hBEEF_0000_0000_0004)) begin tests_failed++; $display("FAIL l3_rddata[%0d]: got %h", k, if3.a_rddata); end
      end
      pulses += int'(if3.a_rvalid) + int'(if3.b_rvalid);
    end
    tests_run++; if (pulses != 6) begin tests_failed++; $display("FAIL l3_pulse_count: got %0d expected 6", pulses); end
  endtask

  task automatic test_reset_drop();
    do_reset();
    @(negedge clk);
    if1.a_req = 1; if1.a_we = '0; if1.a_addr = 12'h005;
    if3.b_req = 1; if3.b_we = '0; if3.b_addr = 12'h005;
    #1;
    tests_run++; if (if3.b_gnt !== 1'b1) begin tests_failed++; $display("FAIL drop_b_gnt: got %b expected 1", if3.b_gnt); end
    @(negedge clk);
    idle_all();
    rstn = 1'b0;
    #1;
    tests_run++; if (if1.a_rvalid !== 1'b0) begin tests_failed++; $display("FAIL drop_l1_a_rvalid: got %b expected 0", if1.a_rvalid); end
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      tests_run++; if ({if3.a_rvalid, if3.b_rvalid} !== 2'b00) begin tests_failed++; $display("FAIL drop_l3_rvalid[%0d]: got %b expected 00", k, {if3.a_rvalid, if3.b_rvalid}); end
    end
    @(negedge clk);
    if1.a_req = 1; if1.a_addr = 12'h006;
    if1.b_req = 1; if1.b_addr = 12'h007;
    #1;
    tests_run++; if ({if1.a_gnt, if1.b_gnt} !== 2'b10) begin tests_failed++; $display("FAIL post_reset_tie: got %b expected 10", {if1.a_gnt, if1.b_gnt}); end
    @(negedge clk);
    idle_all();
  endtask

  task automatic test_no_starvation();
    int b_wait;
    int b_grants;
    b_wait = 0;
    b_grants = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if1.b_req = 1; if1.b_we = '0; if1.b_addr = 12'h008;
      if1.a_req = 1; if1.a_we = '0; if1.a_addr = 12'h009;
      #1;
      tests_run++; if ((if1.a_gnt ^ if1.b_gnt) !== 1'b1) begin tests_failed++; $display("FAIL starve_one_gnt[%0d]: got %b expected one-hot", k, {if1.a_gnt, if1.b_gnt}); end
      if (if1.b_gnt === 1'b1) begin
        b_wait = 0;
        b_grants++;
      end else begin
        b_wait++;
      end
      tests_run++; if (b_wait > 1) begin tests_failed++; $display("FAIL starve_b_wait[%0d]: got %0d expected <=1", k, b_wait); end
    end
    tests_run++; if (b_grants < 4) begin tests_failed++; $display("FAIL starve_b_grants: got %0d expected >=4", b_grants); end
    @(negedge clk);
    idle_all();
  endtask

  // sequence and final report
  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_single_read();
    test_dual_read();
    test_write_read();
    test_latency3();
    test_reset_drop();
    test_no_starvation();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares one single-port BRAM (en/we/addr/wrdata/rddata, fixed read latency) between two requesters, A and B.
- Each requester has a BRAM-style request port with a req/gnt handshake and a read-return channel.
- Round-robin arbitration; the read pipeline tracks ownership so read data returns only to the requester that issued the read.
- Sits between two axi_lite_bram_ctrl-style front ends (or a DMA engine) and one physical BRAM.

Parameters:
DATA_WIDTH, 64, BRAM data width in bits; multiple of 8
BRAM_ADDR_WIDTH, 12, BRAM word address width
READ_LATENCY, 1, cycles from bram_en (read) to valid bram_rddata; legal range 1..4

Ports:
clk  input  1  clock
rstn  input  1  asynchronous active-low reset
a_req  input  1  requester A access request; payload held stable until a_gnt
a_gnt  output  1  A access accepted this cycle (combinational)
a_we  input  DATA_WIDTH/8  A byte write strobes; all-zero means read
a_addr  input  BRAM_ADDR_WIDTH  A word address
a_wrdata  input  DATA_WIDTH  A write data
a_rvalid  output  1  A read data valid (one pulse per granted A read)
a_rddata  output  DATA_WIDTH  A read data
b_req, b_gnt, b_we, b_addr, b_wrdata, b_rvalid, b_rddata  as for A, requester B
bram_en  output  1  BRAM enable
bram_we  output  DATA_WIDTH/8  BRAM byte write enables
bram_addr  output  BRAM_ADDR_WIDTH  BRAM address
bram_wrdata  output  DATA_WIDTH  BRAM write data
bram_rddata  input  DATA_WIDTH  BRAM read data

Behaviour:
- Handshake: an access transfers in the cycle where req && gnt. Requester must keep req and payload stable until gnt. gnt never asserts without req. Back-to-back accesses every cycle are allowed.
- Arbitration (combinational from req and the last_owner register):
  - Only one req high: that requester is granted.
  - Both high: the requester that is not last_owner is granted.
  - last_owner updates on every grant. Reset value is B, so A wins the first tie.
  - Sustained dual requests therefore grant A,B,A,B,...
- At most one gnt per cycle. Full throughput: one access per cycle, no bubbles between owners.
- BRAM drive:
  - bram_en = a_gnt | b_gnt.
  - bram_we, bram_addr, bram_wrdata are muxed from the granted requester.
  - With no grant: bram_we = 0; addr and wrdata are don't-care but must not be X-sensitive for bram_en.
- Read tracking:
  - A READ_LATENCY-deep shift register of {valid, owner} entries is loaded each cycle with valid = grant && we == 0, owner = granted requester.
  - On exit, valid && owner==A drives a_rvalid for 1 cycle; likewise for B.
  - a_rddata = b_rddata = bram_rddata (broadcast); only rvalid is steered.
  - Read-to-rvalid latency is exactly READ_LATENCY cycles, independent of any traffic in between.
- Writes: complete at grant; no response. Any nonzero we is a write.
- Read-after-write to the same address, issued in the next cycle by either requester, returns the new data (BRAM semantics; the arbiter does no reordering).
- Reset (asynchronous, rstn low):
  - Outputs: gnt = 0, bram_en = 0, bram_we = 0, rvalid = 0.
  - Pipeline valid bits cleared; last_owner = B.
  - Reads in flight at reset are dropped and never produce rvalid.
- Requests are ignored while rstn is low. The first grant may occur in the first cycle after rstn deasserts.
- No starvation: a held req is granted within 2 cycles.

Test Plan:
- Reset, then A read @0x010 alone (READ_LATENCY=1) -> a_gnt same cycle, bram_en=1, bram_addr=0x010, bram_we=0; a_rvalid=1 next cycle with BRAM contents; b_rvalid stays 0.
- A and B both hold reads (A@0x1, B@0x2) for 4 cycles -> grants A,B,A,B; bram_addr 1,2,1,2; rvalids alternate a,b,a,b, each exactly 1 cycle after its grant.
- A writes 0xDEADBEEF_00000000 @0x20 with we=0xF0 while B is idle; B reads @0x20 next cycle -> bram_we=0xF0 on the write; b_rvalid returns the updated upper word; a_rvalid never asserts.
- READ_LATENCY=3, A and B reads interleaved every cycle for 6 cycles -> each rvalid appears exactly 3 cycles after its grant on the correct port; 6 total rvalid pulses.
- B issues read, rstn pulsed low for 1 cycle before the data returns -> no b_rvalid; after reset, a simultaneous A/B request grants A first.
- B holds req continuously while A requests every cycle -> B granted at least every 2nd cycle; no starvation.
